// File: rtl/pipelined_addsub_acc_if.sv
// Stream bundle for the pipelined add/sub/accumulate unit: one operand
// stream in, one result stream out, each with its own valid/ready pair.
// Signal prefixes are named from the unit's point of view.
interface pipelined_addsub_acc_if #(
    parameter int WIDTH = 8
);
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [1:0]       i_op;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [WIDTH:0]   o_y;
    logic             o_ovf;

    // Producer/consumer side: drives operands and result acceptance
    modport master (
        output i_in_valid, i_a, i_b, i_op, i_out_ready,
        input  o_in_ready, o_out_valid, o_y, o_ovf
    );

    // Arithmetic unit side
    modport slave (
        input  i_in_valid, i_a, i_b, i_op, i_out_ready,
        output o_in_ready, o_out_valid, o_y, o_ovf
    );
endinterface

// File: rtl/pipelined_addsub_acc.sv
// Pipelined add / subtract / accumulate / clear unit with valid-ready
// handshakes on both sides. Results are WIDTH+1 bits so carry and borrow
// survive. The accumulator updates at acceptance, so back-to-back
// accumulates never see a stale value.
module pipelined_addsub_acc #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2,
    parameter int SAT   = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_addsub_acc_if.slave bus
);
    localparam int YW = WIDTH + 1;

    logic            w_stall;
    logic            w_inReady;
    logic            w_accept;
    logic [WIDTH+1:0] w_sum;
    logic [YW-1:0]   w_accNext;
    logic [YW-1:0]   w_resY;
    logic            w_resOvf;
    logic [YW-1:0]   r_acc;

    // The whole pipe freezes when the last stage holds a result nobody takes
    assign w_stall   = bus.o_out_valid && !bus.i_out_ready;
    assign w_inReady = rst_n && !w_stall;
    assign w_accept  = bus.i_in_valid && w_inReady;
    assign bus.o_in_ready = w_inReady;

    // Result of the beat being offered this cycle, including the wide accumulate sum
    always_comb begin
        w_sum     = {1'b0, r_acc} + {2'b00, bus.i_a};
        w_accNext = w_sum[YW-1:0];
        if (SAT != 0 && w_sum[YW]) begin
            w_accNext = '1;
        end
        w_resY   = '0;
        w_resOvf = 1'b0;
        case (bus.i_op)
            2'b00: w_resY = {1'b0, bus.i_a} + {1'b0, bus.i_b};
            2'b01: w_resY = {1'b0, bus.i_a} - {1'b0, bus.i_b};
            2'b10: begin
                w_resY   = w_accNext;
                w_resOvf = w_sum[YW];
            end
            default: w_resY = '0;
        endcase
    end

    // Accumulator changes only on an accepted accumulate or clear beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            if (bus.i_op == 2'b10) begin
                r_acc <= w_accNext;
            end else if (bus.i_op == 2'b11) begin
                r_acc <= '0;
            end
        end
    end

    for (genvar g = 0; g < PIPE; g++) begin : stage
        logic          r_valid;
        logic [YW:0]   r_pay;

        if (g == 0) begin : firstStage
            // Entry stage captures a payload only when a beat is really accepted
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_pay   <= '0;
                end else if (!w_stall) begin
                    r_valid <= w_accept;
                    if (w_accept) begin
                        r_pay <= {w_resY, w_resOvf};
                    end
                end
            end
        end else begin : laterStage
            // Bubbles move the valid bit but leave the old payload, so the output holds its last value
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_pay   <= '0;
                end else if (!w_stall) begin
                    r_valid <= stage[g-1].r_valid;
                    if (stage[g-1].r_valid) begin
                        r_pay <= stage[g-1].r_pay;
                    end
                end
            end
        end
    end

    assign bus.o_out_valid = stage[PIPE-1].r_valid;
    assign bus.o_y         = stage[PIPE-1].r_pay[YW:1];
    assign bus.o_ovf       = stage[PIPE-1].r_pay[0];
endmodule

// File: tb/tb_pipelined_addsub_acc.sv
// Bench for pipelined_addsub_acc: four instances (8-bit wrap, 8-bit
// saturate, 16-bit PIPE=1, 16-bit PIPE=4) are exercised one at a time,
// with a queue-based arithmetic model and one per-cycle compare process.
module tb_pipelined_addsub_acc;
    logic        clk;
    logic        rst_n;
    logic [3:0]  inValid;
    logic [3:0]  outReady;
    logic [15:0] drvA;
    logic [15:0] drvB;
    logic [1:0]  drvOp;
    logic [3:0]  outValid;
    logic [3:0]  inReady;
    logic [3:0]  outOvf;
    logic [16:0] outY [4];

    int vectors;
    int miscompares;
    int active;
    bit checkEn;
    bit holdPrev;
    logic [16:0] prevY;
    logic        prevOvf;
    logic [17:0] expQ [$];
    logic [17:0] gotQ [$];
    longint accM [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int W = (g < 2) ? 8 : 16;
        localparam int P = (g < 2) ? 2 : ((g == 2) ? 1 : 4);
        localparam int S = (g == 1) ? 1 : 0;

        pipelined_addsub_acc_if #(.WIDTH(W)) bus ();

        assign bus.i_in_valid  = inValid[g];
        assign bus.i_a         = drvA[W-1:0];
        assign bus.i_b         = drvB[W-1:0];
        assign bus.i_op        = drvOp;
        assign bus.i_out_ready = outReady[g];
        assign outValid[g]     = bus.o_out_valid;
        assign inReady[g]      = bus.o_in_ready;
        assign outOvf[g]       = bus.o_ovf;
        assign outY[g]         = 17'(bus.o_y);

        pipelined_addsub_acc #(.WIDTH(W), .PIPE(P), .SAT(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int widthOf(input int idx);
        return (idx < 2) ? 8 : 16;
    endfunction

    function automatic int pipeOf(input int idx);
        case (idx)
            0, 1:    return 2;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected result of one accepted beat, from plain modular arithmetic
    task automatic modelBeat(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        longint m;
        longint aa;
        longint bb;
        longint s;
        longint y;
        logic   ov;
        m  = longint'(1) << (widthOf(idx) + 1);
        aa = longint'(a) & ((longint'(1) << widthOf(idx)) - 1);
        bb = longint'(b) & ((longint'(1) << widthOf(idx)) - 1);
        ov = 1'b0;
        case (op)
            2'b00: y = aa + bb;
            2'b01: y = (aa - bb + m) % m;
            2'b10: begin
                s  = accM[idx] + aa;
                ov = (s >= m);
                if (!ov)        y = s;
                else if (idx == 1) y = m - 1;
                else            y = s - m;
                accM[idx] = y;
            end
            default: begin
                y = 0;
                accM[idx] = 0;
            end
        endcase
        expQ.push_back({y[16:0], ov});
    endtask

    // One cycle of drive, called just after a rising edge; returns whether the beat was taken
    task automatic applyStimulus(input int idx, input logic valid, input logic [15:0] a,
                                 input logic [15:0] b, input logic [1:0] op,
                                 input logic rdy, output bit accepted);
        bit take;
        inValid[idx]  = valid;
        drvA          = a;
        drvB          = b;
        drvOp         = op;
        outReady[idx] = rdy;
        @(negedge clk);
        take = valid && inReady[idx];
        @(posedge clk);
        #1;
        if (take) modelBeat(idx, a, b, op);
        accepted = take;
    endtask

    task automatic drain(input int idx);
        int n;
        inValid[idx]  = 1'b0;
        outReady[idx] = 1'b1;
        n = 0;
        while ((expQ.size() != 0 || outValid[idx]) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) checkOutput("drain_timeout", expQ.size(), 0);
    endtask

    task automatic oneBeat(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        bit acc;
        int tries;
        tries = 0;
        do begin
            applyStimulus(idx, 1'b1, a, b, op, 1'b1, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) checkOutput("accept_timeout", 0, 1);
        drain(idx);
    endtask

    task automatic measureLatency(input int idx, input logic [15:0] a, input logic [15:0] b);
        bit acc;
        int lat;
        applyStimulus(idx, 1'b1, a, b, 2'b00, 1'b1, acc);
        inValid[idx] = 1'b0;
        checkOutput("latency_accept", 32'(acc), 1);
        lat = 1;
        while (!outValid[idx] && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, pipeOf(idx));
        drain(idx);
    endtask

    // Per-cycle check of the active instance against the model queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holdPrev = 1'b0;
            end else if (checkEn) begin
                checkOutput("in_ready", 32'(inReady[active]),
                            32'(!(outValid[active] && !outReady[active])));
                if (holdPrev) begin
                    checkOutput("hold_valid", 32'(outValid[active]), 1);
                    checkOutput("hold_y", 32'(outY[active]), 32'(prevY));
                    checkOutput("hold_ovf", 32'(outOvf[active]), 32'(prevOvf));
                end
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(outValid[active]), 0);
                end else if (outValid[active]) begin
                    checkOutput("y", 32'(outY[active]), 32'(expQ[0][17:1]));
                    checkOutput("ovf", 32'(outOvf[active]), 32'(expQ[0][0]));
                    if (outReady[active]) begin
                        gotQ.push_back({outY[active], outOvf[active]});
                        void'(expQ.pop_front());
                    end
                end
                holdPrev = outValid[active] && !outReady[active];
                prevY    = outY[active];
                prevOvf  = outOvf[active];
            end
        end
    end

    initial begin
        bit acc;
        int i;
        vectors     = 0;
        miscompares = 0;
        active      = 0;
        checkEn     = 1'b0;
        holdPrev    = 1'b0;
        prevY       = '0;
        prevOvf     = 1'b0;
        for (int k = 0; k < 4; k++) accM[k] = 0;
        rst_n    = 1'b0;
        inValid  = '0;
        outReady = '1;
        drvA     = '0;
        drvB     = '0;
        drvOp    = '0;

        #12;
        for (int k = 0; k < 4; k++) begin
            checkOutput("reset_in_ready", 32'(inReady[k]), 0);
            checkOutput("reset_out_valid", 32'(outValid[k]), 0);
            checkOutput("reset_y", 32'(outY[k]), 0);
            checkOutput("reset_ovf", 32'(outOvf[k]), 0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) checkOutput("release_in_ready", 32'(inReady[k]), 1);
        checkEn = 1'b1;

        // Adds with carry and first-result latency
        active = 0;
        gotQ.delete();
        measureLatency(0, 16'h00FF, 16'h0001);
        oneBeat(0, 16'h0000, 16'h0000, 2'b00);
        oneBeat(0, 16'h0003, 16'h0005, 2'b01);
        oneBeat(0, 16'h0005, 16'h0003, 2'b01);
        checkOutput("add_carry", 32'(gotQ[0]), 32'({17'h100, 1'b0}));
        checkOutput("add_zero", 32'(gotQ[1]), 32'({17'h000, 1'b0}));
        checkOutput("sub_borrow", 32'(gotQ[2]), 32'({17'h1FE, 1'b0}));
        checkOutput("sub_plain", 32'(gotQ[3]), 32'({17'h002, 1'b0}));

        // Back-to-back clear and accumulates, wrap then saturate
        for (int idx = 0; idx < 2; idx++) begin
            active = idx;
            gotQ.delete();
            applyStimulus(idx, 1'b1, 16'h0000, 16'h0000, 2'b11, 1'b1, acc);
            for (int k = 0; k < 3; k++) applyStimulus(idx, 1'b1, 16'h00FF, 16'h0000, 2'b10, 1'b1, acc);
            drain(idx);
            checkOutput("acc_count", gotQ.size(), 4);
            if (gotQ.size() == 4) begin
                checkOutput("acc_first", 32'(gotQ[1]), 32'({17'h0FF, 1'b0}));
                checkOutput("acc_second", 32'(gotQ[2]), 32'({17'h1FE, 1'b0}));
                checkOutput("acc_third", 32'(gotQ[3]),
                            (idx == 0) ? 32'({17'h0FD, 1'b1}) : 32'({17'h1FF, 1'b1}));
            end
        end

        // Back-pressure stream of i + i
        active = 0;
        gotQ.delete();
        i = 0;
        while (i < 10) begin
            applyStimulus(0, 1'b1, 16'(i), 16'(i), 2'b00, 1'($urandom_range(0, 1)), acc);
            if (acc) i++;
        end
        drain(0);
        checkOutput("bp_count", gotQ.size(), 10);
        for (int k = 0; k < 10 && k < gotQ.size(); k++)
            checkOutput("bp_order", 32'(gotQ[k][17:1]), 32'(2 * k));

        // Wide operands and latency at PIPE=1 and PIPE=4
        for (int idx = 2; idx < 4; idx++) begin
            active = idx;
            gotQ.delete();
            measureLatency(idx, 16'hFFFF, 16'hFFFF);
            checkOutput("wide_add", 32'(gotQ[0]), 32'({17'h1FFFE, 1'b0}));
        end

        // Reset while two accumulates are still in flight
        active = 3;
        applyStimulus(3, 1'b1, 16'h0007, 16'h0000, 2'b10, 1'b1, acc);
        applyStimulus(3, 1'b1, 16'h0007, 16'h0000, 2'b10, 1'b1, acc);
        inValid[3] = 1'b0;
        rst_n = 1'b0;
        expQ.delete();
        for (int k = 0; k < 4; k++) accM[k] = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) applyStimulus(3, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, acc);
        gotQ.delete();
        oneBeat(3, 16'h0005, 16'h0000, 2'b10);
        checkOutput("acc_after_reset", 32'(gotQ[0]), 32'({17'h005, 1'b0}));

        // Randomised traffic on every configuration
        for (int idx = 0; idx < 4; idx++) begin
            active = idx;
            for (int k = 0; k < 80; k++) begin
                applyStimulus(idx, 1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                              2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), acc);
            end
            drain(idx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub_acc.md
# pipelined_addsub_acc

Parametrised, pipelined arithmetic unit for streaming operand pairs: add, subtract, accumulate and accumulator-clear. Each operation carries a valid/ready handshake on input and output. It replaces single-cycle combinational adders in datapaths that need registered timing, back-pressure or a running sum. Results are WIDTH+1 bits so the carry/borrow is never lost.

## Interface
- WIDTH, 8: operand width in bits (2..32).
- PIPE, 2: register stages from input acceptance to output (1..4).
- SAT, 0: accumulate overflow policy. 0 wraps modulo 2^(WIDTH+1); 1 saturates at 2^(WIDTH+1)-1.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned. Ignored for op 10 and 11.
- op  input  2  operation code: 00 add, 01 sub, 10 accumulate, 11 clear.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result this cycle.
- y  output  WIDTH+1  result.
- ovf  output  1  accumulate wrapped or saturated on this beat.

## Operation
- A beat is accepted when in_valid && in_ready. Each accepted beat produces exactly one output beat. Beats stay in order.
- op 00: y = a + b, zero-extended. Bit WIDTH is the carry.
- op 01: y = a - b, computed WIDTH+1 bits wide, two's complement. Bit WIDTH = 1 iff a < b.
- op 10: acc_next = acc + a, computed at WIDTH+2 bits.
  - SAT=0: acc_next is truncated to WIDTH+1 bits.
  - SAT=1: acc_next clamps to all-ones.
  - y = acc_next. ovf = 1 if the untruncated sum ≥ 2^(WIDTH+1).
- op 11: acc is cleared to 0. y = 0.
- ovf = 0 for op 00, op 01 and op 11.
- acc is a WIDTH+1-bit register. It updates in the cycle the beat is accepted, before the beat enters stage 1. Back-to-back accumulates therefore see every previous accumulate with no hazard.
- Pipeline: PIPE stages, each holding a valid bit plus a {y, ovf} payload. Stages advance together when not stalled.
- Stall: stall = out_valid && !out_ready. When stalled, every stage holds its contents and in_ready = 0.
- in_ready = rst_n && !stall. Bubbles inside the pipe are not compressed while stalled.
- y and ovf are valid only while out_valid = 1. They hold their last value otherwise.

## Timing
- Reset: applies immediately and asynchronously.
  - All stage valid bits = 0 and payloads = 0.
  - acc = 0, out_valid = 0, y = 0, ovf = 0, in_ready = 0.
- After reset release: in_ready = 1 on the first cycle, since out_valid = 0.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+PIPE-1. With PIPE=1 it is visible in the cycle right after the accepting edge.
- Throughput: one beat per cycle while out_ready = 1.
- Output hold: y, ovf and out_valid stay stable while out_valid && !out_ready.
- out_ready deasserting with a valid output: in_ready falls combinationally in the same cycle, and no beat is accepted.
- Accept and emit in the same edge is allowed: the pipe shifts by one stage.
- Reset mid-stream: all in-flight beats and acc are discarded. No partial output appears after release.
- op 11 immediately followed by op 10: the accumulate sees acc = 0.

## Test plan
- Reset, then add 0xFF + 0x01 and 0x00 + 0x00 (WIDTH=8, PIPE=2).
  - Expect y = 0x100 then 0x000, ovf = 0.
  - First out_valid appears exactly 2 edges after acceptance.
- Subtract 0x03 - 0x05 → y = 0x1FE. Subtract 0x05 - 0x03 → y = 0x002.
- Clear, then accumulate 0xFF three times with SAT=0.
  - Expect y = 0x0FF, 0x1FE, then 0x0FD with ovf = 1 on the third.
  - Repeat with SAT=1: third y = 0x1FF, ovf = 1.
- Back-pressure: stream 10 adds of i + i (i = 0..9) with out_ready toggling pseudo-randomly.
  - Expect 10 in-order results 2*i, no loss and no duplication.
  - y stays stable whenever out_valid && !out_ready.
  - in_ready = 0 exactly when stalled.
- Reset mid-operation: accept 2 accumulates, assert rst_n low for 1 cycle before they exit.
  - Expect out_valid = 0 throughout.
  - A following accumulate of 0x05 yields y = 0x005.
- Sweep PIPE = 1 and 4, WIDTH = 16.
  - 0xFFFF + 0xFFFF → 0x1FFFE.
  - Measured latency equals PIPE.
